hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline hazard controller for the five-stage core. It drives the enables of the PC, F/D and D/E registers and the bubble (flush) into the D/E register. Each cycle it compares the source registers of the instruction in D against the pending writes in E and M (Tuse/Tnew stall rule). It also tracks the multi-cycle multiply/divide unit so that HI/LO users in D are held until the unit is free. Forwarding is resolved elsewhere; this block only decides stall and bubble.

## Interface
Parameters:
- MULT_LAT, 5, extra busy cycles after a mult/multu issues in E
- DIV_LAT, 10, extra busy cycles after a div/divu issues in E; must be ≤ 15
- CNT_W, 4, busy-counter width

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; one clock
- rs_D, rt_D  in  5 each  source register numbers of the instruction in D
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until D needs rs/rt; 3 = never used
- A3_E, A3_M  in  5 each  destination register of the instruction in E/M; 0 = no write
- tnew_E, tnew_M  in  2 each  cycles until the E/M result is available
- md_use_D  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  E holds mult/multu/div/divu this cycle
- md_is_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- enable_F  out  1  PC write enable
- enable_D  out  1  F/D register enable
- enable_E  out  1  D/E register enable
- flush_E  out  1  bubble into D/E; OR'd into the D/E register's reset input
- md_busy  out  1  MDU occupied this cycle
- stall_cnt  out  32  stall cycles since reset, saturating at 0xFFFFFFFF

## Operation
- **rs hazard:** rs_D≠0 and ((rs_D==A3_E and tnew_E>tuse_rs_D) or (rs_D==A3_M and tnew_M>tuse_rs_D)).
- **rt hazard:** identical, using rt_D and tuse_rt_D.
- **MDU hazard:** md_use_D and md_busy.
- **stall:** OR of the three hazards.
- **Outputs during stall:** enable_F=0, enable_D=0, enable_E=1, flush_E=1. A NOP enters E; F and D hold.
- **Outputs without stall:** enable_F=enable_D=enable_E=1, flush_E=0.
- **MDU FSM states:** IDLE, BUSY.
  - In IDLE, md_start_E loads cnt=DIV_LAT if md_is_div_E, else MULT_LAT, and moves to BUSY.
  - In BUSY, cnt decrements each cycle. The edge on which cnt goes 1→0 returns the FSM to IDLE.
- **md_busy:** (state==BUSY) or md_start_E. The issue cycle therefore already counts as busy.
- **md_start_E while BUSY:** ignored; the counter keeps running. The stall rule makes this unreachable; the bench asserts it never occurs.
- **stall_cnt:** increments on every clock edge where stall=1, and holds at all-ones.
- **Reset:** state=IDLE, cnt=0, stall_cnt=0, md_busy=0 immediately (asynchronously).
  - While reset is high: enable_F/D/E=1 and flush_E=0. The pipeline registers perform their own reset.
  - Reset during BUSY aborts the count; there is no residual stall after release.

## Timing
- Stall and enable outputs are combinational from the inputs and current state, with zero latency.
- The flush takes effect at the next posedge via the D/E register.
- **mult issued in E at cycle t:** md_busy=1 in cycles t..t+5. An mfhi in D during t..t+5 stalls, and enters E at t+6.
- **div issued at t:** md_busy=1 in t..t+10.
- A load in E (tnew_E=2) with a consumer in D (tuse=1) stalls 1 cycle. In the next cycle the load is in M with tnew_M=1, and the stall clears.
- Register 0 never causes a stall.
- If rs and rt hazards and the MDU hazard occur together, this is one stall and stall_cnt increments by 1.

## Structure
- Shared package hazard_pkg holds:
  - Tuse/Tnew constants, including TUSE_NEVER=3.
  - MULT_LAT_DEF and DIV_LAT_DEF.
  - The MDU state encoding (IDLE=0, BUSY=1).
- One sub-module, md_busy_tracker, contains the FSM, the counter and md_busy.
- The hazard compare and the stall counter live in the top module.

## Test plan
- **RAW on ALU result:** rs_D=8, tuse_rs_D=0, A3_E=8, tnew_E=1 → flush_E=1, enable_F=enable_D=0 for 1 cycle. With rs_D=0 and the same values → no stall.
- **Load-use:** A3_E=9, tnew_E=2, rt_D=9, tuse_rt_D=1 → 1 stall. The next cycle has A3_M=9, tnew_M=1 → no stall. stall_cnt=1.
- **mult then mfhi:** md_start_E=1, md_is_div_E=0 at cycle t, with md_use_D=1 held → stall in t..t+5, released at t+6. stall_cnt=6.
- **div latency:** md_is_div_E=1 → md_busy high for exactly 11 cycles, then 0. No stall when md_use_D=0.
- **Reset mid-div:** assert reset at busy cycle 4 → md_busy=0 at once (asynchronous). After release there is no stall for md_use_D=1, and stall_cnt=0.
- **Saturation:** force stall_cnt to 0xFFFFFFFE, then stall for 3 cycles → 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: Tuse/Tnew encodings,
// default MDU latencies, the MDU state encoding and the source-operand hazard rule.
package hazard_pkg;

    localparam logic [1:0] TUSE_0     = 2'd0;
    localparam logic [1:0] TUSE_1     = 2'd1;
    localparam logic [1:0] TUSE_2     = 2'd2;
    localparam logic [1:0] TUSE_NEVER = 2'd3;

    localparam logic [1:0] TNEW_READY = 2'd0;
    localparam logic [1:0] TNEW_ALU   = 2'd1;
    localparam logic [1:0] TNEW_LOAD  = 2'd2;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam logic MD_IDLE = 1'b0;
    localparam logic MD_BUSY = 1'b1;

    // A source stalls when a pending producer delivers later than the consumer needs it.
    // TUSE_NEVER can never be exceeded by a 2-bit Tnew, so unused operands never stall.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        return (src != 5'd0) &&
               (((src == a3_e) && (tnew_e > tuse)) ||
                ((src == a3_m) && (tnew_m > tuse)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// Multiply/divide unit occupancy tracker: a two-state FSM with a down-counter
// that reports md_busy from the issue cycle through the last busy cycle.
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_is_div_E,
    output logic md_busy
);

    logic             state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_start_E) begin
                        cnt   <= md_is_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        state <= MD_BUSY;
                    end
                end
                default: begin
                    // A start seen here is ignored; the running count is not disturbed.
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= MD_IDLE;
                end
            endcase
        end
    end

    assign md_busy = !reset && ((state == MD_BUSY) || md_start_E);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Five-stage pipeline hazard controller: Tuse/Tnew stall decision, MDU hold
// for HI/LO users, pipeline enables/bubble and a saturating stall counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  A3_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        enable_F,
    output logic        enable_D,
    output logic        enable_E,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic hz_rs;
    logic hz_rt;
    logic hz_md;
    logic stall;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md (
        .clk         (clk),
        .reset       (reset),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .md_busy     (md_busy)
    );

    assign hz_rs = src_hazard(rs_D, tuse_rs_D, A3_E, tnew_E, A3_M, tnew_M);
    assign hz_rt = src_hazard(rt_D, tuse_rt_D, A3_E, tnew_E, A3_M, tnew_M);
    assign hz_md = md_use_D && md_busy;

    // While reset is high the pipeline registers clear themselves, so no stall is raised.
    assign stall = !reset && (hz_rs || hz_rt || hz_md);

    assign enable_F = !stall;
    assign enable_D = !stall;
    assign enable_E = 1'b1;
    assign flush_E  = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule
